// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a - b controller around an external
// single-bit full subtractor. Operands are fed LSB first, one bit pair per
// clock, with the previous borrow returned on fs_z.
// Optional feature: define SERIAL_SUB_SIGNED_EN to add the registered signed
// overflow output.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             fs_x,
  output logic             fs_y,
  output logic             fs_z,
  input  logic             fs_diff,
  input  logic             fs_borrow
`ifdef SERIAL_SUB_SIGNED_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-2:0] diff_sh_q, diff_sh_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_cat;
`ifdef SERIAL_SUB_SIGNED_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Incoming diff bit joined with the bits collected so far
  assign diff_cat = {fs_diff, diff_sh_q};

  // Next-state decode: IDLE -> SHIFT -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (count_q == LAST_BIT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: operand load, per-bit shift, result capture
  always_comb begin
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    diff_sh_d    = diff_sh_q;
    borrow_d     = borrow_q;
    count_d      = count_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    busy_d       = (state_d == SHIFT);
    done_d       = (state_d == DONE);
`ifdef SERIAL_SUB_SIGNED_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    ovf_d        = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d    = a;
          b_sh_d    = b;
          diff_sh_d = '0;
          borrow_d  = 1'b0;
          count_d   = '0;
`ifdef SERIAL_SUB_SIGNED_EN
          a_msb_d   = a[WIDTH-1];
          b_msb_d   = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        diff_sh_d = diff_cat[WIDTH-1:1];
        borrow_d  = fs_borrow;
        a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
        count_d   = count_q + CW'(1);
        if (count_q == LAST_BIT) begin
          diff_d       = diff_cat;
          borrow_out_d = fs_borrow;
`ifdef SERIAL_SUB_SIGNED_EN
          ovf_d        = (a_msb_q ^ b_msb_q) & (fs_diff ^ a_msb_q);
`endif
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      diff_sh_q    <= '0;
      borrow_q     <= 1'b0;
      count_q      <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      diff_sh_q    <= diff_sh_d;
      borrow_q     <= borrow_d;
      count_q      <= count_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SERIAL_SUB_SIGNED_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      ovf_q        <= ovf_d;
`endif
    end
  end

  // busy_q mirrors SHIFT, so the bit pair and borrow are gated to 0 elsewhere
  assign fs_x       = busy_q & a_sh_q[0];
  assign fs_y       = busy_q & b_sh_q[0];
  assign fs_z       = busy_q & borrow_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_SIGNED_EN
  assign overflow   = ovf_q;
`endif

endmodule
